credit_fifo_sender: RTL and testbench

- Transmit end of the credit-based wdata/wvalid/wcredit write interface of the team's snoopable FIFO (140-bit, 78-entry).
- Accepts flits from an upstream valid/ready producer into a 2-entry staging buffer.
- Holds a local credit counter, initialised to the receiver depth.
- Launches one flit per cycle only while credits remain, and regains one credit per wcredit pulse returned by the receiver.

---
 rtl/credit_fifo_sender.sv | 146 ++++++++++++++
 tb/tb_credit_fifo_sender.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/credit_fifo_sender.sv
// credit_fifo_sender: transmit side of the credit-based write link.
// A 2-entry staging buffer absorbs upstream flits. One flit is launched
// per cycle while the local credit counter is non-zero and sending is
// enabled. Each wcredit pulse from the receiver returns one credit.
module credit_fifo_sender #(
  parameter int DW    = 140,
  parameter int DEPTH = 78,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          en,
  output logic [DW-1:0] wdata,
  output logic          wvalid,
  input  logic          wcredit,
  output logic [CW-1:0] credit_cnt,
  output logic          credit_err
);

  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

  state_t        state_reg, state_next;
  logic          rd_idx_reg, wr_idx_reg;
  logic [1:0]    occ_reg, occ_next;
  logic [CW-1:0] cnt_next;
  logic          err_next;
  logic          push, send;
  logic [DW-1:0] head;

  // Readiness depends only on registered occupancy: no pop-to-push bypass.
  assign in_ready = (occ_reg != 2'd2);
  assign push     = in_valid && in_ready;
  assign send     = en && (occ_reg != 2'd0) && (credit_cnt != '0);

  // Staging storage: one register per slot, written when the write index
  // points at it. Data needs no reset; occupancy says what is valid.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DW-1:0] data_reg;
      // Capture an accepted flit into this slot.
      always_ff @(posedge clk) begin
        if (push && (wr_idx_reg == 1'(gi))) begin
          data_reg <= in_data;
        end
      end
    end
  endgenerate

  assign head = rd_idx_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

  // Next occupancy from the push/pop pair.
  always_comb begin
    occ_next = occ_reg;
    if (push && !send) begin
      occ_next = occ_reg + 2'd1;
    end else if (!push && send) begin
      occ_next = occ_reg - 2'd1;
    end
  end

  // Credit arithmetic: a send consumes one credit, a return adds one.
  // A return with nothing outstanding saturates and raises a sticky error.
  always_comb begin
    cnt_next = credit_cnt;
    err_next = credit_err;
    if (send && !wcredit) begin
      cnt_next = credit_cnt - 1'b1;
    end else if (!send && wcredit) begin
      if (credit_cnt == CREDIT_MAX) begin
        err_next = 1'b1;
      end else begin
        cnt_next = credit_cnt + 1'b1;
      end
    end
  end

  // Buffer indices, occupancy and credit state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_idx_reg <= 1'b0;
      wr_idx_reg <= 1'b0;
      occ_reg    <= 2'd0;
      credit_cnt <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      if (push) wr_idx_reg <= ~wr_idx_reg;
      if (send) rd_idx_reg <= ~rd_idx_reg;
      occ_reg    <= occ_next;
      credit_cnt <= cnt_next;
      credit_err <= err_next;
    end
  end

  // Registered launch: wdata keeps its last value between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wvalid <= 1'b0;
      wdata  <= '0;
    end else begin
      wvalid <= send;
      if (send) wdata <= head;
    end
  end

  // Status state machine, judged on next-cycle occupancy and credits.
  // It only tracks link status; launching is decided by send above.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (occ_next != 2'd0) begin
          state_next = (en && (cnt_next != '0)) ? SEND : STALL;
        end
      end
      SEND: begin
        if (occ_next == 2'd0) begin
          state_next = IDLE;
        end else if ((cnt_next == '0) || !en) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if (en && (cnt_next != '0)) begin
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: tb/tb_credit_fifo_sender.sv
// Bench for credit_fifo_sender: directed scenarios plus a random phase,
// checked against a flit-count / credit-count reference model and an
// in-order scoreboard of accepted flits.
module tb_credit_fifo_sender;
  localparam int DW    = 140;
  localparam int DEPTH = 78;
  localparam int CW    = 7;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          en = 1'b0;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wcredit = 1'b0;
  logic [CW-1:0] credit_cnt;
  logic          credit_err;

  credit_fifo_sender #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .wdata(wdata), .wvalid(wvalid),
    .wcredit(wcredit), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  // Reference model state
  logic [DW-1:0] sb_q[$];
  int  m_occ = 0;
  int  m_cred = DEPTH;
  bit  m_err = 1'b0;
  bit  m_wv = 1'b0;
  bit  m_acc = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: staged-flit count, available credits, sticky error.
  always @(posedge clk or negedge rstn) begin
    bit snd;
    if (!rstn) begin
      m_occ = 0; m_cred = DEPTH; m_err = 1'b0; m_wv = 1'b0; m_acc = 1'b0;
      sb_q.delete();
    end else begin
      m_acc = in_valid && (m_occ < 2);
      snd   = en && (m_occ > 0) && (m_cred > 0);
      m_wv  = snd;
      if (m_acc) sb_q.push_back(in_data);
      m_occ = m_occ + int'(m_acc) - int'(snd);
      if (wcredit && !snd && m_cred == DEPTH) m_err = 1'b1;
      else m_cred = m_cred + int'(wcredit) - int'(snd);
    end
  end

  // Monitor: compare every cycle, pop the scoreboard on each launched flit.
  always @(negedge clk) begin
    if (rstn) begin
      chk("wvalid", DW'(wvalid), DW'(m_wv));
      chk("in_ready", DW'(in_ready), DW'(m_occ < 2));
      chk("credit_cnt", DW'(credit_cnt), DW'(m_cred));
      chk("credit_err", DW'(credit_err), DW'(m_err));
      if (wvalid) begin
        n_pulse++;
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wdata: got %0h expected no flit (scoreboard empty)", wdata);
        end else begin
          chk("wdata", wdata, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_flit();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; en = 1'b0; wcredit = 1'b0;
    step(); step();
    chk("rst_wvalid", DW'(wvalid), DW'(0));
    chk("rst_wdata", wdata, DW'(0));
    chk("rst_credit", DW'(credit_cnt), DW'(DEPTH));
    chk("rst_err", DW'(credit_err), DW'(0));
    rstn = 1'b1;
  endtask

  // Offer flits back to back until n have been accepted; wcredit is
  // raised once cr_from flits have been accepted.
  task automatic stream(input int n, input int cr_from);
    int k = 0;
    int cyc = 0;
    in_valid = 1'b1;
    while (k < n && cyc < 1000) begin
      in_data = rnd_flit();
      wcredit = (k >= cr_from);
      step();
      if (m_acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    if (k != n) begin
      n_vec++; n_err++;
      $display("FAIL stream_accept: got %0d expected %0d", k, n);
    end
  endtask

  initial begin
    int base;
    @(negedge clk);

    // Single flit latency
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = DW'(12'hABC);
    step();
    in_valid = 1'b0;
    step();
    chk("single_wvalid", DW'(wvalid), DW'(1));
    chk("single_wdata", wdata, DW'(12'hABC));
    chk("single_credit", DW'(credit_cnt), DW'(77));

    // 80 back-to-back flits, no credits returned
    do_reset();
    en = 1'b1;
    base = n_pulse;
    stream(80, 1000);
    wcredit = 1'b0;
    repeat (5) step();
    chk("exhaust_pulses", DW'(n_pulse - base), DW'(78));
    chk("exhaust_credit", DW'(credit_cnt), DW'(0));
    chk("exhaust_ready", DW'(in_ready), DW'(0));

    // One credit back releases exactly one more flit
    wcredit = 1'b1; step(); wcredit = 1'b0;
    repeat (4) step();
    chk("one_credit_pulses", DW'(n_pulse - base), DW'(79));
    chk("one_credit_cnt", DW'(credit_cnt), DW'(0));

    // Steady state at 5 credits with a return every cycle
    do_reset();
    en = 1'b1;
    stream(110, 74);
    chk("steady_credit", DW'(credit_cnt), DW'(5));
    wcredit = 1'b0;
    repeat (4) step();

    // Spurious credit at full count
    do_reset();
    wcredit = 1'b1; step(); wcredit = 1'b0;
    chk("spurious_credit", DW'(credit_cnt), DW'(DEPTH));
    chk("spurious_err", DW'(credit_err), DW'(1));
    repeat (5) step();
    chk("sticky_err", DW'(credit_err), DW'(1));

    // en=0 holds staged flits; re-enable drains them
    en = 1'b0; in_valid = 1'b1;
    in_data = rnd_flit(); step();
    in_data = rnd_flit(); step();
    in_valid = 1'b0;
    base = n_pulse;
    wcredit = 1'b1; step(); wcredit = 1'b0;
    step();
    chk("en0_pulses", DW'(n_pulse - base), DW'(0));
    chk("en0_credit", DW'(credit_cnt), DW'(DEPTH));
    en = 1'b1;
    repeat (4) step();
    chk("en1_pulses", DW'(n_pulse - base), DW'(2));

    // Asynchronous reset mid-stream
    in_valid = 1'b1;
    repeat (6) begin in_data = rnd_flit(); step(); end
    chk("pre_rst_wvalid", DW'(wvalid), DW'(1));
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_wvalid", DW'(wvalid), DW'(0));
    chk("async_rst_credit", DW'(credit_cnt), DW'(DEPTH));
    chk("async_rst_err", DW'(credit_err), DW'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = rnd_flit();
      en       = ($urandom_range(0, 4) != 0);
      wcredit  = ($urandom_range(0, 9) < 4) && (m_cred < DEPTH - 2);
      step();
    end
    in_valid = 1'b0; wcredit = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
